// File: rtl/id_stage_queued.sv
// Decode stage: valid/ready intake, register-file operand fetch, busy-bit scoreboard, and in-order output queue on req/ack.
// Optional macro ID_STALL_CNT_EN enables the 16-bit saturating hazard-stall counter.

`ifndef OP_MOV
`define OP_MOV            5'h00
`define OP_ADD            5'h01
`define OP_SUB            5'h02
`define OP_AND            5'h03
`define OP_OR             5'h04
`define OP_NOT            5'h05
`define OP_CMP            5'h06
`define OP_MULT           5'h07
`define OP_DIV            5'h08
`define OP_OB_CHECK       5'h09
`define OP_VELOCITY_GUARD 5'h0A
`define OP_MOVE_LEFT      5'h0B
`define OP_MOVE_RIGHT     5'h0C
`define OP_STOP           5'h0D
`define OP_CONTINUE       5'h0E
`endif

module id_stage_queued #(
  parameter int DATA_W     = 16,
  parameter int REG_AW     = 4,
  parameter int OPC_W      = 5,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int PKT_W     = 1 + 2*DATA_W + OPC_W + REG_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic [REG_AW-1:0]  rf_addr_a,
  output logic [REG_AW-1:0]  rf_addr_b,
  input  logic [DATA_W-1:0]  reg_out_A,
  input  logic [DATA_W-1:0]  reg_out_B,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  output logic [PKT_W-1:0]   handshake_data,
  output logic               req,
  input  logic               ack,
  output logic [15:0]        stall_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << REG_AW;

  logic [OPC_W-1:0]  w_opcode;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs1;
  logic [REG_AW-1:0] w_rs2;
  logic              w_is_reg;
  logic              w_is_ctrl;
  logic              w_hazard;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [PKT_W-1:0]  w_pkt;
  logic              w_unused;

  logic [PKT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [NREG-1:0]   r_busy;

  assign w_opcode  = instruction[INSTR_W-1 -: OPC_W];
  assign w_rd      = instruction[INSTR_W-OPC_W-1 -: REG_AW];
  assign w_rs1     = instruction[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign w_rs2     = instruction[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign w_unused  = ^instruction;
  assign rf_addr_a = w_rs1;
  assign rf_addr_b = w_rs2;

  always_comb begin
    w_is_reg  = 1'b0;
    w_is_ctrl = 1'b0;
    case (w_opcode)
      `OP_MOV, `OP_ADD, `OP_SUB, `OP_AND, `OP_OR, `OP_NOT, `OP_CMP,
      `OP_MULT, `OP_DIV, `OP_OB_CHECK, `OP_VELOCITY_GUARD: w_is_reg = 1'b1;
      `OP_MOVE_LEFT, `OP_MOVE_RIGHT, `OP_STOP, `OP_CONTINUE: w_is_ctrl = 1'b1;
      default: ;
    endcase
  end

  // Only register-class instructions read or write the register file, so only they can hazard.
  assign w_hazard = w_is_reg && (r_busy[w_rs1] || r_busy[w_rs2] || r_busy[w_rd]);
  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign in_ready = !reset && !w_full && !w_hazard;
  assign w_push   = in_valid && in_ready;
  assign req      = (r_count != '0);
  assign w_pop    = req && ack;

  assign w_pkt = { !(w_is_reg || w_is_ctrl),
                   w_is_reg ? reg_out_B : {DATA_W{1'b0}},
                   w_is_reg ? reg_out_A : {DATA_W{1'b0}},
                   w_opcode, w_rd };

  assign handshake_data = req ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_pkt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Set on accept wins over a same-cycle writeback clear to the same register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      always_ff @(posedge clk) begin
        if (reset)
          r_busy[gi] <= 1'b0;
        else if (w_push && w_is_reg && (w_rd == REG_AW'(gi)))
          r_busy[gi] <= 1'b1;
        else if (wb_valid && (wb_addr == REG_AW'(gi)))
          r_busy[gi] <= 1'b0;
      end
    end
  endgenerate

`ifdef ID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_stall_cnt <= 16'h0;
    else if (in_valid && w_hazard && !w_full && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'h1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_id_stage_queued.sv
// Directed bench for id_stage_queued: intake, hazards, queue full/drain, illegal opcodes, streaming, reset, stall counter.
// Expected stall count depends on whether ID_STALL_CNT_EN is defined for the build.
`timescale 1ns/1ps

module tb_id_stage_queued;

  localparam int PKT_W = 1 + 2*16 + 5 + 4;

  localparam logic [4:0] OPC_ADD   = 5'h01;
  localparam logic [4:0] OPC_SUB   = 5'h02;
  localparam logic [4:0] OPC_LEFT  = 5'h0B;
  localparam logic [4:0] OPC_STOP  = 5'h0D;
  localparam logic [4:0] OPC_UNDEF = 5'h1F;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [3:0]       rf_addr_a;
  logic [3:0]       rf_addr_b;
  logic [15:0]      reg_out_A;
  logic [15:0]      reg_out_B;
  logic             wb_valid;
  logic [3:0]       wb_addr;
  logic [PKT_W-1:0] handshake_data;
  logic             req;
  logic             ack;
  logic [15:0]      stall_cnt;

  int total = 0;
  int bad   = 0;

  id_stage_queued dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .reg_out_A(reg_out_A), .reg_out_B(reg_out_B), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .handshake_data(handshake_data), .req(req), .ack(ack), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, rd, rs1, rs2, 15'h0};
  endfunction

  function automatic logic [PKT_W-1:0] pk(input logic ill, input logic [15:0] b,
                                          input logic [15:0] a, input logic [4:0] opc,
                                          input logic [3:0] rd);
    return {ill, b, a, opc, rd};
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b1; instruction = mk(OPC_STOP, 4'd0, 4'd0, 4'd0);
    reg_out_A = 16'h0; reg_out_B = 16'h0; wb_valid = 1'b0; wb_addr = 4'd0; ack = 1'b0;
    step(); step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_req", 64'(req), 64'd0);
    check("rst_data", 64'(handshake_data), 64'd0);
    check("rst_stall", 64'(stall_cnt), 64'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("idle_ready", 64'(in_ready), 64'd1);

    // 1: ADD rd=3 rs1=1 rs2=2
    instruction = mk(OPC_ADD, 4'd3, 4'd1, 4'd2);
    reg_out_A = 16'h0011; reg_out_B = 16'h0022; in_valid = 1'b1;
    #1;
    check("t1_addr_a", 64'(rf_addr_a), 64'd1);
    check("t1_addr_b", 64'(rf_addr_b), 64'd2);
    step();
    in_valid = 1'b0;
    check("t1_req", 64'(req), 64'd1);
    check("t1_data", 64'(handshake_data), 64'(pk(1'b0, 16'h0022, 16'h0011, OPC_ADD, 4'd3)));

    // 2: RAW stall on rs1=3 until writeback clears it
    ack = 1'b1; step(); ack = 1'b0;
    check("t2_drained", 64'(req), 64'd0);
    instruction = mk(OPC_SUB, 4'd4, 4'd3, 4'd5);
    reg_out_A = 16'h0033; reg_out_B = 16'h0055; in_valid = 1'b1;
    #1;
    check("t2_stall0", 64'(in_ready), 64'd0);
    step(); check("t2_stall1", 64'(in_ready), 64'd0);
    wb_valid = 1'b1; wb_addr = 4'd3; #1;
    check("t2_stall_wb", 64'(in_ready), 64'd0);
    step(); wb_valid = 1'b0; #1;
    check("t2_ready_after_clr", 64'(in_ready), 64'd1);
    step(); in_valid = 1'b0;
    check("t2_sub_pkt", 64'(handshake_data), 64'(pk(1'b0, 16'h0055, 16'h0033, OPC_SUB, 4'd4)));
    ack = 1'b1; wb_valid = 1'b1; wb_addr = 4'd4;
    step(); ack = 1'b0; wb_valid = 1'b0;

    // 3: fill with four STOPs, then drain in order
    reg_out_A = 16'hAAAA; reg_out_B = 16'hBBBB; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = mk(OPC_STOP, 4'(i), 4'd1, 4'd2);
      step();
    end
    instruction = mk(OPC_STOP, 4'd9, 4'd1, 4'd2);
    check("t3_full_ready", 64'(in_ready), 64'd0);
    check("t3_full_req", 64'(req), 64'd1);
    step();
    in_valid = 1'b0;
    check("t3_hold_head", 64'(handshake_data), 64'(pk(1'b0, 16'h0, 16'h0, OPC_STOP, 4'd0)));
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain%0d", i), 64'(handshake_data),
            64'(pk(1'b0, 16'h0, 16'h0, OPC_STOP, 4'(i))));
      step();
    end
    check("t3_empty", 64'(req), 64'd0);

    // 4: ack on empty queue is ignored; undefined opcode becomes illegal
    step(); ack = 1'b0;
    instruction = mk(OPC_UNDEF, 4'd7, 4'd7, 4'd7); in_valid = 1'b1;
    step(); in_valid = 1'b0;
    check("t4_illegal", 64'(handshake_data), 64'(pk(1'b1, 16'h0, 16'h0, OPC_UNDEF, 4'd7)));
    ack = 1'b1; step(); ack = 1'b0;
    check("t4_single_pop", 64'(req), 64'd0);
    instruction = mk(OPC_ADD, 4'd7, 4'd7, 4'd7); #1;
    check("t4_sb_clean", 64'(in_ready), 64'd1);

    // 5: stream of CTRL packets with ack held high, then reset mid-stream
    ack = 1'b1; in_valid = 1'b1;
    instruction = mk(OPC_LEFT, 4'd0, 4'd0, 4'd0);
    step();
    for (int i = 1; i < 5; i++) begin
      check($sformatf("t5_stream%0d", i), 64'(handshake_data),
            64'(pk(1'b0, 16'h0, 16'h0, OPC_LEFT, 4'(i - 1))));
      check($sformatf("t5_ready%0d", i), 64'(in_ready), 64'd1);
      instruction = mk(OPC_LEFT, 4'(i), 4'd0, 4'd0);
      step();
    end
    reset = 1'b1; step(); reset = 1'b0; in_valid = 1'b0; ack = 1'b0; #1;
    check("t5_rst_req", 64'(req), 64'd0);
    check("t5_rst_data", 64'(handshake_data), 64'd0);

    // 6: hold a RAW stall for seven cycles
    instruction = mk(OPC_ADD, 4'd6, 4'd0, 4'd0); in_valid = 1'b1;
    step();
    instruction = mk(OPC_SUB, 4'd8, 4'd6, 4'd0);
    for (int i = 0; i < 7; i++) step();
    in_valid = 1'b0;
    step();
`ifdef ID_STALL_CNT_EN
    check("t6_stall_cnt", 64'(stall_cnt), 64'd7);
`else
    check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
